mandelbrot_dispatcher: RTL
==========================

// Module: mandelbrot_dispatcher
// PURPOSE
//  Parametrised render sequencer driving NUM_ENGINES mandelbrot engines in parallel. Issues pixel
//  coordinates in raster order round-robin, captures each engine's counter result on its
//  running 1->0 edge, and retires results to the framebuffer strictly in raster order using a
//  one-write-per-ack handshake. Sits between the config/start logic and the VGA framebuffer.
// PARAMETERS
//  NUM_ENGINES  2    engines served, >=1
//  RES_W        4    result (ctr_out) width written to framebuffer
//  WIDTH        400  pixels per row
//  HEIGHT       300  rows per frame
//  (derived) XW=$clog2(WIDTH), YW=$clog2(HEIGHT), EW=max(1,$clog2(NUM_ENGINES))
// PORTS
//  clk           in   1              clock
//  rst_n         in   1              async active-low reset
//  start         in   1              1-cycle pulse: begin frame (ignored while busy)
//  busy          out  1              frame in progress
//  done          out  1              1-cycle pulse after last pixel acked
//  eng_run       out  NUM_ENGINES    one-hot 1-cycle start pulse to engine k
//  eng_x         out  XW             pixel x for the engine pulsed this cycle
//  eng_y         out  YW             pixel y for the engine pulsed this cycle
//  eng_running   in   NUM_ENGINES    per-engine running flag
//  eng_result    in   NUM_ENGINES*RES_W  per-engine result, slice k = [k*RES_W +: RES_W]
//  fb_reset_ptr  out  1              1-cycle pulse: rewind framebuffer write pointer
//  fb_write      out  1              1-cycle pulse: fb_data valid
//  fb_data       out  RES_W          pixel result
//  fb_wrote      in   1              framebuffer ack; next fb_write only after it
//  stall_cycles  out  32             retire-stall counter (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; slots FREE; x=y=0; dptr=rptr=0; writer idle.
//  FSM: IDLE -start-> CLEAR (fb_reset_ptr=1 one cycle) -> RUN -> (retired==WIDTH*HEIGHT) DONE
//   (done=1 one cycle) -> IDLE. busy=1 in CLEAR/RUN/DONE.
//  Slot k states FREE->COMPUTING->READY->FREE.
//  Dispatch (RUN, at most one per cycle): if slot[dptr]==FREE and issued<total: eng_run[dptr]=1,
//   eng_x/eng_y=current x/y, slot->COMPUTING, dptr=(dptr+1)%NUM_ENGINES, x++ ; x wraps
//   WIDTH-1->0 with y++. No dispatch once y==HEIGHT-1,x==WIDTH-1 has issued.
//  Capture: register eng_running each cycle; fall (prev=1,now=0) on slot COMPUTING ->
//   latch eng_result slice, slot->READY. Falls on non-COMPUTING slots ignored.
//  Retire: if writer idle and slot[rptr]==READY: fb_write=1, fb_data=slot data, slot->FREE,
//   rptr++ (mod), writer waits for fb_wrote; fb_wrote in same cycle as fb_write ignored.
//  Same-cycle retire of slot k and dispatch to k is not allowed (dispatch sees FREE next cycle).
//  Order guarantee: dispatch and retire both round-robin -> fb order == raster order regardless
//   of per-engine latency.
//  NUM_ENGINES==1 degenerates to serial compute/write; pointers stay 0.
//  start during busy: ignored. Reset mid-frame: immediate abort, state as at reset; engines
//   still running are ignored until the next frame (their falls hit FREE slots).
// CONFIGURATION
//  Macro MANDELBROT_DISPATCH_STALL_CNT_EN:
//   defined: stall_cycles clears on start, increments (saturating) each RUN cycle where
//   slot[rptr]!=READY and writer idle; holds after done.  undefined: stall_cycles tied 0,
//   counter logic absent.
// STRUCTURE
//  Package tiny_mandelbrot_pkg: slot_state_e {SLOT_FREE,SLOT_COMPUTING,SLOT_READY},
//   disp_state_e {D_IDLE,D_CLEAR,D_RUN,D_DONE}, RES_W default constant.
//  Sub-module dispatch_slot (one per engine, generate loop): state, result reg, fall detect;
//   inputs dispatch/retire strobes, outputs state and data.
// TESTING
//  1. NUM_ENGINES=1, WIDTH=4,HEIGHT=2, engine model latency 3, fb_wrote 2 cycles after write
//     -> 8 fb_write in x-major order, fb_reset_ptr once before first, done once after 8th ack.
//  2. NUM_ENGINES=4, random per-pixel latency 1..20, result=(x+y)%16 -> fb_data stream equals
//     raster sequence exactly; eng_run never two-hot.
//  3. fb_wrote held off 50 cycles -> no second fb_write, dispatch stalls once all slots READY.
//  4. start pulsed during RUN -> ignored; no extra fb_reset_ptr; frame completes normally.
//  5. rst_n low mid-frame, then start -> outputs 0 during reset, fresh frame from (0,0),
//     stale engine falls do not produce fb_write.
//  6. MACRO defined, engine latency 10, NUM_ENGINES=1, instant ack -> stall_cycles ==
//     pixels*(stall per pixel) precomputed; undefined -> stall_cycles==0 throughout.

Source files
------------

// File: rtl/tiny_mandelbrot_pkg.sv
// tiny_mandelbrot_pkg: slot and dispatcher state encodings plus default result width.
package tiny_mandelbrot_pkg;
   typedef enum logic [1:0] {SLOT_FREE, SLOT_COMPUTING, SLOT_READY} slot_state_e;
   typedef enum logic [1:0] {D_IDLE, D_CLEAR, D_RUN, D_DONE} disp_state_e;
   localparam int DEF_RES_W = 4;
endpackage

// File: rtl/dispatch_slot.sv
// dispatch_slot: per-engine slot tracking FREE/COMPUTING/READY, capturing the result
// on the engine's running 1->0 edge.
module dispatch_slot
   import tiny_mandelbrot_pkg::*;
#(
   parameter int RES_W = DEF_RES_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dispatch,
   input  logic             retire,
   input  logic             running,
   input  logic [RES_W-1:0] result,
   output slot_state_e      state,
   output logic [RES_W-1:0] data
);
   logic prev;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SLOT_FREE;
         data  <= '0;
         prev  <= 1'b0;
      end else begin
         prev <= running;
         if (dispatch) state <= SLOT_COMPUTING;
         else if (state == SLOT_COMPUTING && prev && !running) begin
            state <= SLOT_READY;
            data  <= result;
         end else if (retire) state <= SLOT_FREE;
      end
   end
endmodule

// File: rtl/mandelbrot_dispatcher.sv
// mandelbrot_dispatcher: round-robin pixel dispatch to NUM_ENGINES engines with in-order retire.
// Optional retire-stall counter enabled by MANDELBROT_DISPATCH_STALL_CNT_EN.
module mandelbrot_dispatcher
   import tiny_mandelbrot_pkg::*;
#(
   parameter int NUM_ENGINES = 2,
   parameter int RES_W       = DEF_RES_W,
   parameter int WIDTH       = 400,
   parameter int HEIGHT      = 300,
   localparam int XW = $clog2(WIDTH),
   localparam int YW = $clog2(HEIGHT),
   localparam int EW = NUM_ENGINES > 1 ? $clog2(NUM_ENGINES) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   output logic                         busy,
   output logic                         done,
   output logic [NUM_ENGINES-1:0]       eng_run,
   output logic [XW-1:0]                eng_x,
   output logic [YW-1:0]                eng_y,
   input  logic [NUM_ENGINES-1:0]       eng_running,
   input  logic [NUM_ENGINES*RES_W-1:0] eng_result,
   output logic                         fb_reset_ptr,
   output logic                         fb_write,
   output logic [RES_W-1:0]             fb_data,
   input  logic                         fb_wrote,
   output logic [31:0]                  stall_cycles
);
   localparam int TOTAL = WIDTH * HEIGHT;
   localparam int CW = $clog2(TOTAL + 1);

   disp_state_e state, nxt;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [EW-1:0] dptr, rptr;
   logic [CW-1:0] retired;
   logic all_issued, wait_ack, disp, ret;
   logic [NUM_ENGINES-1:0] is_free, is_ready;
   slot_state_e sst [NUM_ENGINES];
   logic [RES_W-1:0] sdata [NUM_ENGINES];

   for (genvar i = 0; i < NUM_ENGINES; i++) begin : g_slot
      dispatch_slot #(.RES_W(RES_W)) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .dispatch (disp && dptr == EW'(i)),
         .retire   (ret && rptr == EW'(i)),
         .running  (eng_running[i]),
         .result   (eng_result[i*RES_W +: RES_W]),
         .state    (sst[i]),
         .data     (sdata[i])
      );
      assign is_free[i]  = sst[i] == SLOT_FREE;
      assign is_ready[i] = sst[i] == SLOT_READY;
   end

   always_comb begin
      nxt = state;
      if (state == D_IDLE && start) nxt = D_CLEAR;
      else if (state == D_CLEAR) nxt = D_RUN;
      else if (state == D_RUN && retired == CW'(TOTAL)) nxt = D_DONE;
      else if (state == D_DONE) nxt = D_IDLE;
   end

   assign busy         = state != D_IDLE;
   assign done         = state == D_DONE;
   assign fb_reset_ptr = state == D_CLEAR;
   assign disp         = state == D_RUN && !all_issued && is_free[dptr];
   assign ret          = state == D_RUN && !wait_ack && is_ready[rptr];
   assign eng_run      = disp ? NUM_ENGINES'(1) << dptr : '0;
   assign eng_x        = x;
   assign eng_y        = y;
   assign fb_write     = ret;
   assign fb_data      = sdata[rptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= D_IDLE;
         x          <= '0;
         y          <= '0;
         dptr       <= '0;
         rptr       <= '0;
         retired    <= '0;
         all_issued <= 1'b0;
         wait_ack   <= 1'b0;
      end else begin
         state <= nxt;
         if (state == D_CLEAR) begin
            x          <= '0;
            y          <= '0;
            dptr       <= '0;
            rptr       <= '0;
            retired    <= '0;
            all_issued <= 1'b0;
            wait_ack   <= 1'b0;
         end else begin
            if (disp) begin
               dptr       <= dptr == EW'(NUM_ENGINES - 1) ? '0 : dptr + 1'b1;
               all_issued <= x == XW'(WIDTH - 1) && y == YW'(HEIGHT - 1);
               x          <= x == XW'(WIDTH - 1) ? '0 : x + 1'b1;
               y          <= x == XW'(WIDTH - 1) ? y + 1'b1 : y;
            end
            // an ack arriving alongside fb_write is ignored because wait_ack is still low
            if (ret) begin
               rptr     <= rptr == EW'(NUM_ENGINES - 1) ? '0 : rptr + 1'b1;
               wait_ack <= 1'b1;
            end else if (wait_ack && fb_wrote) begin
               wait_ack <= 1'b0;
               retired  <= retired + 1'b1;
            end
         end
      end
   end

`ifdef MANDELBROT_DISPATCH_STALL_CNT_EN
   logic [31:0] stall_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else if (state == D_IDLE && start) stall_q <= '0;
      else if (state == D_RUN && !wait_ack && !is_ready[rptr] && stall_q != '1) stall_q <= stall_q + 1'b1;
   end
   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif
endmodule
